alu_mul_seq: RTL
================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  in  1  request a multiply; sampled only in IDLE.
REQ-004 SHALL have: opA  in  16  multiplicand; opB  in  16  multiplier; both captured when start is accepted.
REQ-005 SHALL have: busy  out  1  high in every state except IDLE.
REQ-006 SHALL have: done  out  1  one-cycle pulse, high only in DONE.
REQ-007 SHALL have: result  out  16  registered low 16 bits of opA*opB; result_z  out  1  (result==0); result_n  out  1  result[15].
REQ-008 SHALL drive the shared ALU: alu_op  out  3; alu_a  out  16; alu_b  out  16; and read alu_result  in  16.
REQ-009 Clock and reset are fixed: one clock; reset is asynchronous and active-low.

Function
REQ-010 SHALL implement FSM states IDLE, EVAL, ADD, SHIFT, DONE.
REQ-011 IDLE: on start=1 -> acc<=0, mcand<=opA, mplier<=opB, cnt<=0, next EVAL; else stay.
REQ-012 EVAL: mplier[0]=1 -> ADD; else -> SHIFT; alu_op=PASS(100), alu_a=0, alu_b=0.
REQ-013 ADD: alu_op=ADD(001), alu_a=acc, alu_b=mcand; acc<=alu_result; next SHIFT.
REQ-014 SHIFT: alu_op=LSL(010), alu_a=mcand, alu_b=16'd1; mcand<=alu_result; mplier<=mplier>>1; cnt<=cnt+1; cnt==15 -> DONE, else EVAL.
REQ-015 DONE: result<=acc at entry edge, done=1 for exactly one cycle, next IDLE.
REQ-016 IDLE and DONE SHALL drive alu_op=PASS, alu_a=0, alu_b=0.
REQ-017 ALU result SHALL be consumed in the same cycle it is driven (combinational ALU, single-cycle path).
REQ-018 Arithmetic SHALL be modulo 2^16; upper product bits are discarded, no overflow flag.
REQ-019 Latency: done high in cycle 33+popcount(opB) counting the start-accept cycle as cycle 0.
REQ-020 start while busy (including DONE) SHALL be ignored; opA/opB changes while busy SHALL have no effect.
REQ-021 result/result_z/result_n SHALL hold their value until the next DONE.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, result_z=1, result_n=0, acc/mcand/mplier/cnt=0, alu_op=PASS, alu_a=alu_b=0.
REQ-023 Reset mid-operation SHALL abandon the operation with no done pulse; first start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro ALU_MUL_SEQ_EARLY_EXIT_EN defined: in EVAL, mplier==0 -> DONE directly (latency 2+2*(msb_index(opB)+1)+popcount(opB), opB=0 -> 2).
REQ-025 Macro undefined: always 16 iterations, latency per REQ-019; result identical in both builds.

Structure
REQ-026 Shared package alu_pkg SHALL hold ALU op encodings (SUB=000, ADD=001, LSL=010, NEG=011, PASS=100, CMP=101) and the FSM state enum.
REQ-027 No sub-module; the ALU instance lives in the parent and is connected via alu_* ports.

Verification
REQ-028 opA=3, opB=5, start at cycle 0 -> done at cycle 35, result=0x000F, result_z=0.
REQ-029 opA=0x1234, opB=0 -> result=0x0000, result_z=1; done at cycle 33 (cycle 2 with EARLY_EXIT_EN).
REQ-030 opA=0xFFFF, opB=0xFFFF -> result=0x0001, result_n=0, done at cycle 49.
REQ-031 opA=0x0100, opB=0x0100 -> result=0x0000 (wrap), result_z=1, done at cycle 34; opA=0x4000, opB=2 -> result=0x8000, result_n=1.
REQ-032 start pulsed with new operands at cycles 5 and at done cycle -> ignored, original result delivered, busy low one cycle after done.
REQ-033 rst_n low at cycle 10 of a multiply -> all outputs at reset values same cycle, no done; subsequent 7*6 -> 0x002A.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encodings and the sequential multiplier FSM state enum.
// Contents:
//   alu_op_e - 3-bit ALU operation codes driven on alu_op
//   state_e  - FSM states of alu_mul_seq
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_SUB  = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_LSL  = 3'b010,
        ALU_NEG  = 3'b011,
        ALU_PASS = 3'b100,
        ALU_CMP  = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16x16 (mod 2^16) multiplier sequenced over an external shared ALU.
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   start, opA, opB      - request; operands captured when start is accepted in IDLE
//   busy, done           - busy outside IDLE; done is a one-cycle pulse in DONE
//   result, result_z/_n  - registered product (low 16 bits), zero flag, sign bit
//   alu_op, alu_a, alu_b - request to the combinational shared ALU
//   alu_result           - ALU answer, consumed in the same cycle
// Configuration:
//   ALU_MUL_SEQ_EARLY_EXIT_EN - when defined, EVAL finishes as soon as the
//                               remaining multiplier bits are all zero.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        result_z,
    output logic        result_n,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result
);

    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        alu_op   = ALU_PASS;
        alu_a    = '0;
        alu_b    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_EVAL;
                    acc_d    = '0;
                    mcand_d  = opA;
                    mplier_d = opB;
                    cnt_d    = '0;
                end
            end
            S_EVAL: begin
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                if (mplier_q == 16'd0) begin
                    state_d  = S_DONE;
                    result_d = acc_q;
                end else begin
                    state_d = mplier_q[0] ? S_ADD : S_SHIFT;
                end
`else
                state_d = mplier_q[0] ? S_ADD : S_SHIFT;
`endif
            end
            S_ADD: begin
                alu_op  = ALU_ADD;
                alu_a   = acc_q;
                alu_b   = mcand_q;
                acc_d   = alu_result;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                alu_op   = ALU_LSL;
                alu_a    = mcand_q;
                alu_b    = 16'd1;
                mcand_d  = alu_result;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                // Termination is decided in EVAL; after 16 shifts mplier is zero.
                state_d = S_EVAL;
`else
                if (cnt_q == 4'd15) begin
                    state_d  = S_DONE;
                    result_d = acc_q;
                end else begin
                    state_d = S_EVAL;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;
    assign result   = result_q;
    assign result_z = result_q == 16'd0;
    assign result_n = result_q[15];

endmodule
